// File: rtl/program_mem_if.sv
// Fetch and loader signal bundle for program_mem.
// Signal names are given from the memory's point of view: i_* flow into it, o_* flow out of it.
interface program_mem_if #(
  parameter int unsigned INSTR_W = 18,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 64
);
  localparam int unsigned LEN_W = $clog2(DEPTH + 1);

  // Fetch port
  logic               i_fetch;
  logic [ADDR_W-1:0]  i_addr;
  logic [INSTR_W-1:0] o_instr;
  logic               o_valid;
  logic               o_oob;

  // Streaming loader port
  logic               i_ld_start;
  logic               i_ld_valid;
  logic [INSTR_W-1:0] i_ld_data;
  logic               i_ld_last;
  logic               o_ld_ready;

  // Program status
  logic               o_loaded;
  logic [LEN_W-1:0]   o_len;

  // Fetch unit / loader side
  modport master (
    output i_fetch, i_addr, i_ld_start, i_ld_valid, i_ld_data, i_ld_last,
    input  o_instr, o_valid, o_oob, o_ld_ready, o_loaded, o_len
  );

  // Memory side
  modport slave (
    input  i_fetch, i_addr, i_ld_start, i_ld_valid, i_ld_data, i_ld_last,
    output o_instr, o_valid, o_oob, o_ld_ready, o_loaded, o_len
  );
endinterface

// File: rtl/program_mem.sv
// Loadable synchronous program memory for the CPU fetch stage.
// A streaming loader fills words from address 0 upward; fetches at or beyond the loaded
// length return NOP with o_oob set. Reads are registered with one cycle of latency.
module program_mem #(
  parameter int unsigned        INSTR_W = 18,
  parameter int unsigned        ADDR_W  = 16,
  parameter int unsigned        DEPTH   = 64,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input logic           i_clk,
  input logic           i_rst_n,
  program_mem_if.slave  bus
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReady
  } state_e;

  state_e             state_q, state_d;
  // Doubles as the write pointer while loading: both start at 0 and advance together.
  logic [LEN_W-1:0]   len_q, len_d;
  logic               loaded_q, loaded_d;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] rd_q;
  logic               nop_sel_q;
  logic               valid_q;
  logic               oob_q;

  logic               ld_ready;
  logic               beat_acc;
  logic               fetch_served;
  logic               fetch_oob;
  logic               at_last_word;
  logic [IDX_W-1:0]   waddr;
  logic [IDX_W-1:0]   raddr;

  // Handshake and fetch qualification
  always_comb begin
    ld_ready     = (state_q == StLoad) && (len_q < LEN_W'(DEPTH));
    // A start in the same cycle restarts the load and drops the beat.
    beat_acc     = ld_ready && bus.i_ld_valid && !bus.i_ld_start;
    // Fetches are ignored while loading and lose to a simultaneous start.
    fetch_served = bus.i_fetch && (state_q != StLoad) && !bus.i_ld_start;
    // Full-width zero-extended compare; nothing wraps into the array.
    fetch_oob    = (state_q == StIdle) || (CMP_W'(bus.i_addr) >= CMP_W'(len_q));
    at_last_word = (len_q == LEN_W'(DEPTH - 1));
    waddr        = len_q[IDX_W-1:0];
    raddr        = bus.i_addr[IDX_W-1:0];
  end

  // Next-state logic for the load controller
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_ld_start) begin
          state_d  = StLoad;
          len_d    = '0;
          loaded_d = 1'b0;
        end
      end
      StLoad: begin
        if (bus.i_ld_start) begin
          len_d = '0;
        end else if (beat_acc) begin
          len_d = len_q + LEN_W'(1);
          // Filling the final word ends the load even without a last marker.
          if (bus.i_ld_last || at_last_word) begin
            state_d  = StReady;
            loaded_d = 1'b1;
          end
        end
      end
      StReady: begin
        if (bus.i_ld_start) begin
          state_d  = StLoad;
          len_d    = '0;
          loaded_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Controller state registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      loaded_q <= loaded_d;
    end
  end

  // Single-write-port RAM with registered read; contents survive reset
  always_ff @(posedge i_clk) begin
    if (beat_acc) begin
      mem[waddr] <= bus.i_ld_data;
    end
    // Only in-bounds reads touch the array, so raddr is always a valid index here.
    if (fetch_served && !fetch_oob) begin
      rd_q <= mem[raddr];
    end
  end

  // Fetch result flags; all hold their value between served fetches
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      oob_q     <= 1'b0;
      nop_sel_q <= 1'b1;
    end else begin
      valid_q <= fetch_served;
      if (fetch_served) begin
        oob_q     <= fetch_oob;
        nop_sel_q <= fetch_oob;
      end
    end
  end

  // Output mux sits after registers only, so i_addr never reaches o_instr combinationally.
  always_comb begin
    bus.o_instr    = nop_sel_q ? NOP : rd_q;
    bus.o_valid    = valid_q;
    bus.o_oob      = oob_q;
    bus.o_ld_ready = ld_ready;
    bus.o_loaded   = loaded_q;
    bus.o_len      = len_q;
  end

endmodule

// File: tb/tb_program_mem.sv
// Directed bench for program_mem: reset, load, fetch, bounds, overflow, restart, reset mid-load
// and start/fetch collision.
module tb_program_mem;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DEPTH   = 64;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  program_mem_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  program_mem #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .NOP     (18'h00000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_fetch    = 1'b0;
    bus.i_addr     = '0;
    bus.i_ld_start = 1'b0;
    bus.i_ld_valid = 1'b0;
    bus.i_ld_data  = '0;
    bus.i_ld_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    vecs++; if (bus.o_instr !== 18'h0) begin errs++; $display("FAIL reset_instr: got %h want 00000", bus.o_instr); end
    vecs++; if (bus.o_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    vecs++; if (bus.o_oob !== 1'b0) begin errs++; $display("FAIL reset_oob: got %b want 0", bus.o_oob); end
    vecs++; if (bus.o_ld_ready !== 1'b0) begin errs++; $display("FAIL reset_ld_ready: got %b want 0", bus.o_ld_ready); end
    vecs++; if (bus.o_loaded !== 1'b0) begin errs++; $display("FAIL reset_loaded: got %b want 0", bus.o_loaded); end
    vecs++; if (bus.o_len !== 7'd0) begin errs++; $display("FAIL reset_len: got %0d want 0", bus.o_len); end
    // Fetch while idle
    bus.i_fetch = 1'b1;
    bus.i_addr  = 16'd0;
    step();
    bus.i_fetch = 1'b0;
    vecs++; if (bus.o_valid !== 1'b1) begin errs++; $display("FAIL idle_fetch_valid: got %b want 1", bus.o_valid); end
    vecs++; if (bus.o_oob !== 1'b1) begin errs++; $display("FAIL idle_fetch_oob: got %b want 1", bus.o_oob); end
    vecs++; if (bus.o_instr !== 18'h0) begin errs++; $display("FAIL idle_fetch_instr: got %h want 00000", bus.o_instr); end
  endtask

  task automatic test_load6();
    logic [INSTR_W-1:0] prog [6];
    prog = '{18'h00038, 18'h32800, 18'h31000, 18'h00018, 18'h3A400, 18'h31000};
    bus.i_ld_start = 1'b1;
    step();
    bus.i_ld_start = 1'b0;
    vecs++; if (bus.o_ld_ready !== 1'b1) begin errs++; $display("FAIL load6_ready: got %b want 1", bus.o_ld_ready); end
    for (int i = 0; i < 6; i++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = prog[i];
      bus.i_ld_last  = (i == 5);
      step();
    end
    bus.i_ld_valid = 1'b0;
    bus.i_ld_last  = 1'b0;
    vecs++; if (bus.o_len !== 7'd6) begin errs++; $display("FAIL load6_len: got %0d want 6", bus.o_len); end
    vecs++; if (bus.o_loaded !== 1'b1) begin errs++; $display("FAIL load6_loaded: got %b want 1", bus.o_loaded); end
    vecs++; if (bus.o_ld_ready !== 1'b0) begin errs++; $display("FAIL load6_ready_off: got %b want 0", bus.o_ld_ready); end
    // Back-to-back fetches, one result per cycle
    for (int i = 0; i < 6; i++) begin
      bus.i_fetch = 1'b1;
      bus.i_addr  = 16'(i);
      step();
      vecs++; if (bus.o_instr !== prog[i] || bus.o_valid !== 1'b1 || bus.o_oob !== 1'b0) begin
        errs++;
        $display("FAIL b2b_fetch[%0d]: got instr=%h valid=%b oob=%b want instr=%h valid=1 oob=0",
                 i, bus.o_instr, bus.o_valid, bus.o_oob, prog[i]);
      end
    end
    bus.i_fetch = 1'b0;
    step();
    vecs++; if (bus.o_valid !== 1'b0 || bus.o_instr !== 18'h31000) begin
      errs++;
      $display("FAIL hold_instr: got instr=%h valid=%b want instr=31000 valid=0", bus.o_instr, bus.o_valid);
    end
  endtask

  task automatic test_oob();
    logic [ADDR_W-1:0] addrs [3];
    addrs = '{16'd6, 16'hFFFF, 16'd63};
    for (int i = 0; i < 3; i++) begin
      bus.i_fetch = 1'b1;
      bus.i_addr  = addrs[i];
      step();
      bus.i_fetch = 1'b0;
      vecs++; if (bus.o_instr !== 18'h0 || bus.o_valid !== 1'b1 || bus.o_oob !== 1'b1) begin
        errs++;
        $display("FAIL oob_fetch[%h]: got instr=%h valid=%b oob=%b want instr=00000 valid=1 oob=1",
                 addrs[i], bus.o_instr, bus.o_valid, bus.o_oob);
      end
    end
  endtask

  task automatic test_full();
    bus.i_ld_start = 1'b1;
    step();
    bus.i_ld_start = 1'b0;
    // 65 beats offered, no last marker; the 65th must be refused
    for (int i = 0; i < 65; i++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = 18'h10000 + 18'(i);
      bus.i_ld_last  = 1'b0;
      #1;
      if (i == 63 || i == 64) begin
        vecs++; if (bus.o_ld_ready !== (i < 64)) begin
          errs++;
          $display("FAIL full_ready[%0d]: got %b want %b", i, bus.o_ld_ready, (i < 64));
        end
      end
      step();
    end
    bus.i_ld_valid = 1'b0;
    vecs++; if (bus.o_len !== 7'd64) begin errs++; $display("FAIL full_len: got %0d want 64", bus.o_len); end
    vecs++; if (bus.o_loaded !== 1'b1) begin errs++; $display("FAIL full_loaded: got %b want 1", bus.o_loaded); end
    bus.i_fetch = 1'b1;
    bus.i_addr  = 16'd63;
    step();
    vecs++; if (bus.o_instr !== 18'h1003F || bus.o_oob !== 1'b0) begin
      errs++; $display("FAIL full_fetch63: got instr=%h oob=%b want instr=1003f oob=0", bus.o_instr, bus.o_oob);
    end
    bus.i_addr = 16'd0;
    step();
    vecs++; if (bus.o_instr !== 18'h10000 || bus.o_oob !== 1'b0) begin
      errs++; $display("FAIL full_fetch0: got instr=%h oob=%b want instr=10000 oob=0", bus.o_instr, bus.o_oob);
    end
    bus.i_addr = 16'd64;
    step();
    bus.i_fetch = 1'b0;
    vecs++; if (bus.o_instr !== 18'h0 || bus.o_oob !== 1'b1) begin
      errs++; $display("FAIL full_fetch64: got instr=%h oob=%b want instr=00000 oob=1", bus.o_instr, bus.o_oob);
    end
  endtask

  task automatic test_restart();
    bus.i_ld_start = 1'b1;
    step();
    bus.i_ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = 18'h0A000 + 18'(i);
      step();
    end
    vecs++; if (bus.o_len !== 7'd3 || bus.o_loaded !== 1'b0) begin
      errs++; $display("FAIL restart_pre: got len=%0d loaded=%b want len=3 loaded=0", bus.o_len, bus.o_loaded);
    end
    // Restart with a valid beat present: the beat must be dropped
    bus.i_ld_start = 1'b1;
    bus.i_ld_data  = 18'h3FFFF;
    step();
    bus.i_ld_start = 1'b0;
    vecs++; if (bus.o_len !== 7'd0 || bus.o_ld_ready !== 1'b1) begin
      errs++; $display("FAIL restart_clear: got len=%0d ready=%b want len=0 ready=1", bus.o_len, bus.o_ld_ready);
    end
    bus.i_ld_data = 18'h0B000;
    step();
    bus.i_ld_data = 18'h0B001;
    bus.i_ld_last = 1'b1;
    step();
    bus.i_ld_valid = 1'b0;
    bus.i_ld_last  = 1'b0;
    vecs++; if (bus.o_len !== 7'd2 || bus.o_loaded !== 1'b1) begin
      errs++; $display("FAIL restart_len: got len=%0d loaded=%b want len=2 loaded=1", bus.o_len, bus.o_loaded);
    end
    bus.i_fetch = 1'b1;
    bus.i_addr  = 16'd2;
    step();
    vecs++; if (bus.o_instr !== 18'h0 || bus.o_oob !== 1'b1) begin
      errs++; $display("FAIL restart_fetch2: got instr=%h oob=%b want instr=00000 oob=1", bus.o_instr, bus.o_oob);
    end
    bus.i_addr = 16'd1;
    step();
    vecs++; if (bus.o_instr !== 18'h0B001 || bus.o_oob !== 1'b0) begin
      errs++; $display("FAIL restart_fetch1: got instr=%h oob=%b want instr=0b001 oob=0", bus.o_instr, bus.o_oob);
    end
    bus.i_addr = 16'd0;
    step();
    bus.i_fetch = 1'b0;
    vecs++; if (bus.o_instr !== 18'h0B000 || bus.o_oob !== 1'b0) begin
      errs++; $display("FAIL restart_fetch0: got instr=%h oob=%b want instr=0b000 oob=0", bus.o_instr, bus.o_oob);
    end
  endtask

  task automatic test_reset_midload();
    bus.i_ld_start = 1'b1;
    step();
    bus.i_ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.i_ld_valid = 1'b1;
      bus.i_ld_data  = 18'h0C000 + 18'(i);
      step();
    end
    bus.i_ld_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vecs++; if (bus.o_len !== 7'd0 || bus.o_loaded !== 1'b0 || bus.o_ld_ready !== 1'b0) begin
      errs++; $display("FAIL midrst_state: got len=%0d loaded=%b ready=%b want len=0 loaded=0 ready=0",
                       bus.o_len, bus.o_loaded, bus.o_ld_ready);
    end
    vecs++; if (bus.o_valid !== 1'b0 || bus.o_oob !== 1'b0 || bus.o_instr !== 18'h0) begin
      errs++; $display("FAIL midrst_outs: got valid=%b oob=%b instr=%h want valid=0 oob=0 instr=00000",
                       bus.o_valid, bus.o_oob, bus.o_instr);
    end
    bus.i_fetch = 1'b1;
    bus.i_addr  = 16'd0;
    step();
    bus.i_fetch = 1'b0;
    vecs++; if (bus.o_instr !== 18'h0 || bus.o_oob !== 1'b1 || bus.o_valid !== 1'b1) begin
      errs++; $display("FAIL midrst_fetch0: got instr=%h oob=%b valid=%b want instr=00000 oob=1 valid=1",
                       bus.o_instr, bus.o_oob, bus.o_valid);
    end
  endtask

  task automatic test_fetch_start();
    bus.i_ld_start = 1'b1;
    step();
    bus.i_ld_start = 1'b0;
    bus.i_ld_valid = 1'b1;
    bus.i_ld_data  = 18'h2D2D2;
    bus.i_ld_last  = 1'b1;
    step();
    bus.i_ld_valid = 1'b0;
    bus.i_ld_last  = 1'b0;
    bus.i_fetch    = 1'b1;
    bus.i_addr     = 16'd0;
    step();
    vecs++; if (bus.o_instr !== 18'h2D2D2 || bus.o_valid !== 1'b1) begin
      errs++; $display("FAIL collide_pre: got instr=%h valid=%b want instr=2d2d2 valid=1", bus.o_instr, bus.o_valid);
    end
    // Start and fetch together in READY: start wins
    bus.i_ld_start = 1'b1;
    step();
    bus.i_ld_start = 1'b0;
    vecs++; if (bus.o_valid !== 1'b0 || bus.o_ld_ready !== 1'b1 || bus.o_len !== 7'd0) begin
      errs++; $display("FAIL collide: got valid=%b ready=%b len=%0d want valid=0 ready=1 len=0",
                       bus.o_valid, bus.o_ld_ready, bus.o_len);
    end
    // Fetch still asserted during LOAD is ignored and o_instr holds
    step();
    bus.i_fetch = 1'b0;
    vecs++; if (bus.o_valid !== 1'b0 || bus.o_instr !== 18'h2D2D2) begin
      errs++; $display("FAIL load_fetch_ignored: got valid=%b instr=%h want valid=0 instr=2d2d2",
                       bus.o_valid, bus.o_instr);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_load6();
    test_oob();
    test_full();
    test_restart();
    test_reset_midload();
    test_fetch_start();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/program_mem.md
Name: program_mem

Overview:
- Parametrised, loadable, synchronous program memory feeding the CPU fetch stage.
- Successor to the fixed combinational program ROM. Adds configurable width and depth, registered read, and a streaming loader with valid/ready handshake.
- Any fetch of an address that has not been loaded returns a NOP word and raises an out-of-bounds flag.
- Sits between the fetch unit (16-bit PC) and the boot/debug loader.

Parameters:
- INSTR_W, 18, instruction word width in bits.
- ADDR_W, 16, fetch address width (PC width).
- DEPTH, 64, number of instruction words stored; 1..2^ADDR_W.
- NOP, 18'h00000, word returned for unloaded or out-of-range fetches.
- LEN_W (localparam) = clog2(DEPTH+1).

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, active-low, synchronous.
- i_fetch  in  1  fetch request for i_addr this cycle.
- i_addr  in  ADDR_W  fetch address.
- o_instr  out  INSTR_W  fetched word, registered.
- o_valid  out  1  o_instr valid this cycle.
- o_oob  out  1  qualifies o_valid; set when the fetched address was >= o_len (NOP returned).
- i_ld_start  in  1  begin a new load at address 0.
- i_ld_valid  in  1  loader beat valid.
- i_ld_data  in  INSTR_W  loader beat data.
- i_ld_last  in  1  final beat marker.
- o_ld_ready  out  1  loader beat accepted when valid and ready.
- o_loaded  out  1  a load has completed since reset.
- o_len  out  LEN_W  number of words in the current program.

Behaviour:
- Reset:
  - Synchronous, active-low. Sampled on i_clk only.
  - Output reset values: o_instr=NOP, o_valid=0, o_oob=0, o_ld_ready=0, o_loaded=0, o_len=0. State goes to IDLE.
  - Memory array is not cleared by reset.
- States: IDLE, LOAD, READY.
- IDLE:
  - o_ld_ready=0.
  - Fetches are served with NOP and o_oob=1.
  - i_ld_start moves to LOAD.
- LOAD:
  - On entry, write pointer=0 and o_len=0. o_ld_ready=1 while the pointer < DEPTH.
  - Each accepted beat (valid & ready) writes mem[ptr] and increments ptr and o_len.
  - Accepted beat with i_ld_last=1 → READY next cycle, o_loaded=1.
  - Beat that fills word DEPTH-1 → READY regardless of i_ld_last. o_ld_ready=0 from the next cycle.
  - i_ld_start during LOAD restarts at ptr 0, o_len=0. No write occurs that cycle.
  - Fetches during LOAD are ignored: o_valid=0.
  - o_loaded drops to 0 on LOAD entry.
- READY:
  - o_ld_ready=0. Fetches are served normally.
  - i_ld_start → LOAD, contents reloaded from address 0.
- Fetch latency is 1 cycle: i_fetch at cycle N → o_valid=1 at N+1.
  - If i_addr < o_len: o_instr=mem[i_addr], o_oob=0.
  - Otherwise: o_instr=NOP, o_oob=1.
  - Comparison uses the full ADDR_W bits, zero-extended. No wrap-around; addresses >= DEPTH are always out of bounds.
  - o_valid=0 in any cycle without a served fetch. o_instr holds its last value.
- Back-to-back fetches: one result per cycle, in request order.
- Simultaneous events:
  - i_ld_start with i_fetch in READY or IDLE: start wins and the fetch is dropped (o_valid=0 next cycle).
  - i_ld_start with an accepted beat in LOAD: restart wins and the beat is dropped.
  - A fetch whose address equals a word written in the same cycle: not possible, since fetches are ignored in LOAD.
- Reset mid-load:
  - Returns to IDLE with o_len=0 and o_loaded=0.
  - Partially written words remain in the array but are unreachable (out of bounds) until a new load completes.
- Zero-length program is not possible: the minimum load is 1 beat (the beat carrying last).
- Implementation: inferred synchronous-read RAM with a single write port; no combinational path from i_addr to o_instr.

Test Plan:
- Reset, then load 6 beats 0x00038, 0x32800, 0x31000, 0x00018, 0x3A400, 0x31000 (last on beat 6) → o_len=6, o_loaded=1. Fetches at 0..5 return those words one cycle later, o_oob=0.
- After that load, fetch addr 6 and addr 0xFFFF → o_instr=0x00000, o_valid=1, o_oob=1. Fetch in IDLE right after reset → NOP, o_oob=1.
- Load DEPTH=64 beats without last, keeping i_ld_valid high for a 65th beat → o_ld_ready falls after beat 64, o_len=64, beat 65 not written. Fetch 63 returns beat 64 data.
- Load 3 words, assert i_ld_start mid-load, then load 2 words with last → o_len=2. Fetch 2 → o_oob=1. Fetch 1 returns the new word.
- Deassert i_rst_n for 1 cycle during a load after 4 beats → next cycle all outputs at reset values. Fetch 0 → NOP, o_oob=1.
- i_fetch and i_ld_start together in READY → o_valid=0 next cycle, state LOAD, o_ld_ready=1.
